// File: rtl/ram_arbiter_if.sv
// Requester and SDRAM-side signal bundle for ram_arbiter.
// slave: the arbiter's view; master: the view of the surrounding system.
interface ram_arbiter_if;
    logic        dma_req;
    logic        tape_req;
    logic        cpu_req;
    logic        dma_we;
    logic        cpu_we;
    logic [24:0] dma_addr;
    logic [24:0] tape_addr;
    logic [24:0] cpu_addr;
    logic [7:0]  dma_din;
    logic [7:0]  cpu_din;
    logic        dma_ack;
    logic        tape_ack;
    logic        cpu_ack;
    logic [7:0]  rd_data;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic        mem_ready;
    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  dma_req, tape_req, cpu_req, dma_we, cpu_we,
        input  dma_addr, tape_addr, cpu_addr, dma_din, cpu_din,
        input  mem_dout, mem_ready,
        output dma_ack, tape_ack, cpu_ack, rd_data,
        output mem_addr, mem_din, mem_rd, mem_we, grant, busy
    );

    modport master (
        output dma_req, tape_req, cpu_req, dma_we, cpu_we,
        output dma_addr, tape_addr, cpu_addr, dma_din, cpu_din,
        output mem_dout, mem_ready,
        input  dma_ack, tape_ack, cpu_ack, rd_data,
        input  mem_addr, mem_din, mem_rd, mem_we, grant, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Three-way sequencer (DMA > tape > CPU) for the shared SDRAM byte port.
// Define RAM_ARB_STARVE_GUARD_EN to compile in the CPU starvation guard.
module ram_arbiter #(
    parameter int unsigned SETTLE_CYC   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [1:0] GrantNone = 2'd0;
    localparam logic [1:0] GrantDma  = 2'd1;
    localparam logic [1:0] GrantTape = 2'd2;
    localparam logic [1:0] GrantCpu  = 2'd3;

    if (SETTLE_CYC < 1 || SETTLE_CYC > 7) begin : g_bad_settle
        $error("SETTLE_CYC must be 1..7");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("STARVE_LIMIT must be 1..15");
    end

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        we_q, we_d;
    logic [24:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_we_q, mem_we_d;
    logic        dma_ack_q, dma_ack_d;
    logic        tape_ack_q, tape_ack_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [2:0]  settle_q, settle_d;
    logic [2:0]  settle_inc;
    logic        starve_force;
    logic [1:0]  win;
    logic        win_we;
    logic [24:0] win_addr;
    logic [7:0]  win_din;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic [3:0]  starve_q, starve_d;
    assign starve_force = bus.cpu_req && (starve_q == 4'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        win      = GrantNone;
        win_we   = 1'b0;
        win_addr = bus.cpu_addr;
        win_din  = bus.cpu_din;
        if (starve_force) begin
            win    = GrantCpu;
            win_we = bus.cpu_we;
        end else if (bus.dma_req) begin
            win      = GrantDma;
            win_we   = bus.dma_we;
            win_addr = bus.dma_addr;
            win_din  = bus.dma_din;
        end else if (bus.tape_req) begin
            win      = GrantTape;
            win_addr = bus.tape_addr;
            win_din  = 8'h00;
        end else if (bus.cpu_req) begin
            win    = GrantCpu;
            win_we = bus.cpu_we;
        end
    end

    assign settle_inc = (settle_q == 3'(SETTLE_CYC)) ? settle_q : settle_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        mem_rd_d   = 1'b0;
        mem_we_d   = 1'b0;
        dma_ack_d  = 1'b0;
        tape_ack_d = 1'b0;
        cpu_ack_d  = 1'b0;
        rd_data_d  = rd_data_q;
        settle_d   = settle_q;
`ifdef RAM_ARB_STARVE_GUARD_EN
        starve_d   = starve_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win != GrantNone) begin
                    grant_d  = win;
                    we_d     = win_we;
                    addr_d   = win_addr;
                    din_d    = win_din;
                    // Strobes are registered so they are high during the ISSUE cycle.
                    mem_rd_d = ~win_we;
                    mem_we_d = win_we;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                settle_d = 3'd0;
                state_d  = StWait;
            end
            StWait: begin
                settle_d = settle_inc;
                if (settle_inc == 3'(SETTLE_CYC) && bus.mem_ready) begin
                    if (!we_q) rd_data_d = bus.mem_dout;
                    dma_ack_d  = (grant_q == GrantDma);
                    tape_ack_d = (grant_q == GrantTape);
                    cpu_ack_d  = (grant_q == GrantCpu);
                    state_d    = StDone;
                end
            end
            StDone: begin
`ifdef RAM_ARB_STARVE_GUARD_EN
                if (grant_q != GrantCpu && bus.cpu_req) begin
                    starve_d = (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
                end else begin
                    starve_d = 4'd0;
                end
`endif
                grant_d = GrantNone;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            grant_q    <= GrantNone;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            dma_ack_q  <= 1'b0;
            tape_ack_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            rd_data_q  <= '0;
            settle_q   <= '0;
`ifdef RAM_ARB_STARVE_GUARD_EN
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            dma_ack_q  <= dma_ack_d;
            tape_ack_q <= tape_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            rd_data_q  <= rd_data_d;
            settle_q   <= settle_d;
`ifdef RAM_ARB_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.dma_ack  = dma_ack_q;
    assign bus.tape_ack = tape_ack_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected accesses are queued when requests are
// raised and checked against strobes and acks; the sram model returns addr[7:0]^0xA5.
module tb_ram_arbiter;

    localparam int unsigned SettleCyc   = 2;
    localparam int unsigned StarveLimit = 4;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    ram_arbiter_if bus ();

    ram_arbiter #(
        .SETTLE_CYC   (SettleCyc),
        .STARVE_LIMIT (StarveLimit)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.mem_dout = bus.mem_addr[7:0] ^ 8'hA5;

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] last_rd  = 8'h00;
    int         reps[4];
    int         cyc = 0;
    int         last_ack_cyc = 0;
    int         prev_ack_cyc = 0;
    int         n_strobes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [1:0] id, input logic we, input logic [24:0] addr,
                        input logic [7:0] din);
        exp_t e;
        e.id = id; e.we = we; e.addr = addr; e.din = din;
        exp_q.push_back(e);
    endtask

    // One cycle: sample on the falling edge, check strobes/acks, retire requesters.
    task automatic tick();
        logic [2:0] acks;
        logic [1:0] id;
        exp_t       e;
        @(negedge clk_sys);
        cyc++;
        if (bus.mem_rd || bus.mem_we) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", 1, 0);
            end else begin
                check("strobe_we", bus.mem_we, exp_q[0].we);
                check("strobe_rd", bus.mem_rd, !exp_q[0].we);
                check("strobe_addr", bus.mem_addr, exp_q[0].addr);
                check("strobe_grant", bus.grant, exp_q[0].id);
                if (exp_q[0].we) check("strobe_din", bus.mem_din, exp_q[0].din);
            end
        end
        acks = {bus.cpu_ack, bus.tape_ack, bus.dma_ack};
        if (acks != 3'b000) begin
            id = acks[2] ? 2'd3 : (acks[1] ? 2'd2 : 2'd1);
            check("ack_onehot", $countones(acks), 1);
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_id", id, e.id);
                check("ack_grant", bus.grant, e.id);
                if (!e.we) last_rd = e.addr[7:0] ^ 8'hA5;
                check("ack_rd_data", bus.rd_data, last_rd);
            end
            prev_ack_cyc = last_ack_cyc;
            last_ack_cyc = cyc;
            if (reps[id] > 0) begin
                reps[id]--;
            end else begin
                case (id)
                    2'd1:    bus.dma_req  = 1'b0;
                    2'd2:    bus.tape_req = 1'b0;
                    default: bus.cpu_req  = 1'b0;
                endcase
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !bus.busy && !bus.dma_req && !bus.tape_req &&
                !bus.cpu_req) return;
            tick();
        end
        check({tag, "_timeout"}, 0, 1);
        exp_q.delete();
        bus.dma_req  = 1'b0;
        bus.tape_req = 1'b0;
        bus.cpu_req  = 1'b0;
    endtask

    initial begin
        int t0;
        int s0;
        int bad_ack;
        int bad_addr;

        for (int i = 0; i < 4; i++) reps[i] = 0;
        reset_n       = 1'b0;
        bus.dma_req   = 1'b0;
        bus.tape_req  = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.dma_addr  = '0;
        bus.tape_addr = '0;
        bus.cpu_addr  = '0;
        bus.dma_din   = '0;
        bus.cpu_din   = '0;
        bus.mem_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_strobes", {bus.mem_rd, bus.mem_we}, 0);
        check("rst_acks", {bus.dma_ack, bus.tape_ack, bus.cpu_ack}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_rd_data", bus.rd_data, 0);
        reset_n = 1'b1;
        tick();

        // CPU read alone: latency and 1-cycle strobe
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 25'h0014000;
        bus.cpu_req  = 1'b1;
        push(2'd3, 1'b0, 25'h0014000, 8'h00);
        t0 = cyc;
        tick();
        check("cpu_issue_rd", bus.mem_rd, 1);
        check("cpu_issue_grant", bus.grant, 3);
        tick();
        check("cpu_strobe_1cyc", bus.mem_rd, 0);
        wait_idle("cpu_rd");
        check("cpu_latency", 32'(last_ack_cyc - t0), SettleCyc + 2);
        check("cpu_rd_data", bus.rd_data, 8'hA5);
        check("cpu_grant_cleared", bus.grant, 0);

        // Simultaneous requests resolve DMA, tape, CPU; back-to-back period
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 25'h0400000;
        bus.dma_din   = 8'h3C;
        bus.tape_addr = 25'h0000123;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 25'h0014077;
        bus.dma_req   = 1'b1;
        bus.tape_req  = 1'b1;
        bus.cpu_req   = 1'b1;
        push(2'd1, 1'b1, 25'h0400000, 8'h3C);
        push(2'd2, 1'b0, 25'h0000123, 8'h00);
        push(2'd3, 1'b0, 25'h0014077, 8'h00);
        wait_idle("simul");
        check("b2b_period", 32'(last_ack_cyc - prev_ack_cyc), SettleCyc + 3);

        // Starvation: tape held for five grants while the CPU waits
        bus.tape_addr = 25'h0000100;
        bus.cpu_addr  = 25'h0014000;
        reps[2]       = 4;
        bus.tape_req  = 1'b1;
        bus.cpu_req   = 1'b1;
`ifdef RAM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < StarveLimit; i++) push(2'd2, 1'b0, 25'h0000100, 8'h00);
        push(2'd3, 1'b0, 25'h0014000, 8'h00);
        push(2'd2, 1'b0, 25'h0000100, 8'h00);
`else
        for (int i = 0; i < 5; i++) push(2'd2, 1'b0, 25'h0000100, 8'h00);
        push(2'd3, 1'b0, 25'h0014000, 8'h00);
`endif
        wait_idle("starve");

        // Slow memory: ack waits for mem_ready, address held throughout
        bus.mem_ready = 1'b0;
        bus.cpu_addr  = 25'h0000055;
        bus.cpu_req   = 1'b1;
        push(2'd3, 1'b0, 25'h0000055, 8'h00);
        tick();
        tick();
        bad_ack  = 0;
        bad_addr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cpu_ack) bad_ack++;
            if (bus.mem_addr !== 25'h0000055) bad_addr++;
        end
        check("slow_no_ack", bad_ack, 0);
        check("slow_addr_stable", bad_addr, 0);
        bus.mem_ready = 1'b1;
        tick();
        check("slow_ack_next", bus.cpu_ack, 1);
        wait_idle("slow");

        // Reset mid-WAIT aborts; the held DMA request restarts from ISSUE
        bus.mem_ready = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 25'h0000233;
        bus.dma_req   = 1'b1;
        push(2'd1, 1'b0, 25'h0000233, 8'h00);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("rstw_busy", bus.busy, 0);
        check("rstw_grant", bus.grant, 0);
        check("rstw_no_ack", bus.dma_ack, 0);
        last_rd = 8'h00;
        tick();
        tick();
        check("rstw_rd_data", bus.rd_data, 0);
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        check("rstw_reissue", bus.mem_rd, 1);
        wait_idle("rstw");

        // Requester drops during WAIT: ack still pulses, single access only
        bus.mem_ready = 1'b0;
        bus.cpu_addr  = 25'h0000777;
        bus.cpu_req   = 1'b1;
        push(2'd3, 1'b0, 25'h0000777, 8'h00);
        s0 = n_strobes;
        tick();
        tick();
        bus.cpu_req = 1'b0;
        tick();
        tick();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drop_acked", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) tick();
        check("drop_one_access", n_strobes - s0, 1);
        check("drop_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
